// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader
//   Serial-to-parallel front end for matrix_multiplier. Collects n*m 32-bit
//   words (row-major or column-major arrival) into a flat row-major bus and
//   presents it with a strobe until the consumer acknowledges it.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   asynchronous active-high reset
//   in_data    in   [31:0] incoming element, valid while in_stb=1
//   in_stb     in   upstream has a word on in_data
//   in_ack     out  loader can take a word (registered)
//   matrix_out out  [0:32*n*m-1] element (r,c) at [(r*m+c)*32 +: 32]
//   out_stb    out  matrix_out complete and stable (registered)
//   out_ack    in   downstream accepts the matrix
//   dbg_state  out  [1:0] current FSM state (0 IDLE, 1 FILL, 2 PRESENT)
//
// Handshake: on both ports a transfer happens on a rising edge where stb=1
// and ack=1; the producer holds stb and data stable until that edge. in_ack
// and out_stb are never high together, so at most one transfer per edge.
module matrix_operand_loader #(
  parameter int n         = 2,
  parameter int m         = 2,
  parameter bit col_major = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       in_data,
  input  logic              in_stb,
  output logic              in_ack,
  output logic [0:32*n*m-1] matrix_out,
  output logic              out_stb,
  input  logic              out_ack,
  output logic [1:0]        dbg_state
);

  localparam int NE = n * m;
  localparam int RW = (n > 1) ? $clog2(n) : 1;
  localparam int CW = (m > 1) ? $clog2(m) : 1;
  localparam int KW = (NE > 1) ? $clog2(NE) : 1;
  // One spare bit so row*m+col never wraps for any legal row/col.
  localparam int IW = KW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_in_ack;
  logic              r_out_stb;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [KW-1:0]     r_count;
  logic [0:32*n*m-1] r_matrix;

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_last;
  logic [IW-1:0]     w_wr_idx;

  assign w_in_xfer  = in_stb & r_in_ack;
  assign w_out_xfer = out_ack & r_out_stb;
  assign w_last     = (r_count == KW'(NE - 1));
  assign w_wr_idx   = IW'(r_row) * IW'(m) + IW'(r_col);

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    w_next_state = S_FILL;
      S_FILL:    if (w_in_xfer && w_last) w_next_state = S_PRESENT;
      S_PRESENT: if (w_out_xfer) w_next_state = S_FILL;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // State register; handshake outputs are registered from the next state so
  // they change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_in_ack  <= 1'b0;
      r_out_stb <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_in_ack  <= (w_next_state == S_FILL);
      r_out_stb <= (w_next_state == S_PRESENT);
    end
  end

  // Position counters: row and column kept separately so the write address
  // needs only a constant multiply, no divide or modulo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row   <= '0;
      r_col   <= '0;
      r_count <= '0;
    end else if (w_in_xfer) begin
      if (w_last) begin
        r_row   <= '0;
        r_col   <= '0;
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
        if (!col_major) begin
          if (r_col == CW'(m - 1)) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end else begin
          if (r_row == RW'(n - 1)) begin
            r_row <= '0;
            r_col <= r_col + 1'b1;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
      end
    end
  end

  // Element storage. Only written on an accepted input word, so the bus is
  // frozen while presenting. Not cleared between matrices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_matrix <= '0;
    end else if (w_in_xfer) begin
      for (int e = 0; e < NE; e++) begin
        if (w_wr_idx == IW'(e)) r_matrix[e*32 +: 32] <= in_data;
      end
    end
  end

  assign in_ack     = r_in_ack;
  assign out_stb    = r_out_stb;
  assign matrix_out = r_matrix;
  assign dbg_state  = r_state;

endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Serial-to-parallel front end for `matrix_multiplier`. It accepts one 32-bit IEEE-754 single-precision word per stb/ack transfer and assembles an n×m operand matrix into the flat bus format the multiplier expects. It then presents that bus with a strobe until the multiplier acknowledges it. One instance drives `matrix_A`/`a_stb`/`a_ack`, a second drives `matrix_B`/`b_stb`/`b_ack`.

## Interface
- `n`, default 2: matrix rows.
- `m`, default 2: matrix columns.
- `col_major`, default 0: input word order. 0 = row-major arrival, 1 = column-major arrival. Output is always row-major.
- `clk`  in  1: clock; all state changes on rising edge.
- `rst`  in  1: reset; one clock, asynchronous, active-high.
- `in_data`  in  32: incoming matrix element, valid while `in_stb`=1.
- `in_stb`  in  1: upstream has a word on `in_data`.
- `in_ack`  out  1: loader can take a word.
- `matrix_out`  out  [0:32*n*m-1]: assembled matrix. Element (r,c) is at `[(r*m+c)*32 +: 32]`, so word 0 sits at the MSB end.
- `out_stb`  out  1: `matrix_out` is complete and stable.
- `out_ack`  in  1: downstream (multiplier `a_ack`/`b_ack`) accepts the matrix.

## Operation
- Transfer rule, both ports: a transfer occurs on a rising edge where stb=1 and ack=1. The producer holds stb and data until that edge.
- States: IDLE, FILL, PRESENT. All outputs are registered.
- Reset forces IDLE, `in_ack`=0, `out_stb`=0, `matrix_out`=0, and clears the row counter, column counter and element count.
- IDLE: on the first edge with `rst`=0, go to FILL and set `in_ack`=1.
- FILL: each input transfer writes `in_data` into element (row,col). Then advance the counters:
  - `col_major`=0: col++ ; on col==m-1, col←0 and row++.
  - `col_major`=1: row++ ; on row==n-1, row←0 and col++.
  - Counters are kept separately, so no divide or modulo is needed.
- FILL, last element (count==n*m-1) transferred: on that same edge, go to PRESENT, set `in_ack`←0, `out_stb`←1, and reset the counters to 0.
- PRESENT:
  - `matrix_out` is frozen.
  - `in_stb` is ignored; no ack is given and no write occurs.
  - On an output transfer, set `out_stb`←0, go to FILL, and set `in_ack`←1.
- `matrix_out` is not cleared between matrices. Each element is overwritten as the next matrix fills. Downstream may only sample it while `out_stb`=1.
- Data is stored bit-exact; the block does no floating-point interpretation.
- n=m=1: the first input transfer goes straight to PRESENT.

## Timing
- Input throughput: one word per cycle while `in_stb` is held high in FILL.
- The last input transfer at edge t gives `out_stb`=1 and `in_ack`=0 from t onward, i.e. visible in cycle t+1.
- An output transfer at edge t gives `out_stb`=0 and `in_ack`=1 in cycle t+1. There is no bubble beyond that single cycle.
- Minimum period per matrix: n*m cycles of input plus 1 cycle of output handshake.
- `out_ack` asserted while `out_stb`=0 is ignored.
- `in_stb` and `out_ack` may be high on the same edge. Only the transfer legal in the current state takes effect; the two ports are never both ready at once.
- Reset asserted mid-FILL or mid-PRESENT: immediate asynchronous return to reset values. The partial matrix is discarded and the next fill starts at element (0,0).

## Test plan
- Row-major 2×2: with n=m=2, `col_major`=0, send 3F800000, 40000000, 40400000, 40800000 back-to-back, with `out_ack` held 0.
  - Required: `matrix_out` = 3F800000_40000000_40400000_40800000.
  - `out_stb` rises 1 cycle after the 4th transfer, and `in_ack`=0 while it is high.
- Column-major 2×2: same four words with `col_major`=1.
  - Required: `matrix_out` = 3F800000_40400000_40000000_40800000.
- Backpressure and gaps: toggle `in_stb` randomly (e.g. a word every 3rd cycle).
  - Required: exactly 4 writes and the same result as the row-major case; no duplicated or skipped words.
- Present hold: keep `out_ack`=0 for 10 cycles while `in_stb`=1 with data DEADBEEF.
  - Required: `in_ack` stays 0, `matrix_out` is unchanged, `out_stb` stays 1.
  - Then pulse `out_ack` for 1 cycle. Required: `out_stb`=0 and `in_ack`=1 the next cycle.
- Reset mid-fill: send 2 words, assert `rst` asynchronously between edges.
  - Required: outputs go to 0 immediately, before the next edge.
  - After release, 4 new words (40A00000, 40C00000, 40E00000, 41000000) yield exactly 40A00000_40C00000_40E00000_41000000.
- System loop: two loaders feeding `matrix_multiplier` (n=m=p=2) with A = 1,2,3,4 and B = identity.
  - Required: the multiplier raises `c_stb` with C = A (3F800000_40000000_40400000_40800000).
  - Both loaders return to FILL after `a_ack`/`b_ack`.
